accel_multi_axis_sequencer: RTL and testbench

- Parametrised successor to the single-axis swipe sequencer; drives the existing 32-bit SPI master handshake.
- Probes the LIS3DH WHO_AM_I register with bounded retry, then writes the init table.
- Then loops at a programmable rate, reading NUM_AXES 16-bit axes by auto-increment reads, publishing samples, and tracking per-axis direction with a threshold band.
- Sits between the SPI master and the LED/text display logic.

---
 rtl/accel_seq_pkg.sv | 47 ++++
 rtl/accel_axis_cmp.sv | 42 ++++
 rtl/accel_multi_axis_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_accel_multi_axis_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_seq_pkg.sv
`default_nettype none
// accel_seq_pkg: sequencer states, LIS3DH command words, init table, LED patterns
// and the signed threshold classifier shared by the sequencer blocks. Rev 1.0
package accel_seq_pkg;

  typedef enum logic [3:0] {
    WHOAMI      = 4'd0,
    WHOAMI_WAIT = 4'd1,
    CHECK       = 4'd2,
    INIT        = 4'd3,
    INIT_WAIT   = 4'd4,
    READ        = 4'd5,
    READ_WAIT   = 4'd6,
    COMPARE     = 4'd7,
    PERIOD      = 4'd8,
    FAULT       = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CLS_CEN = 2'd0,
    CLS_POS = 2'd1,
    CLS_NEG = 2'd2
  } cls_t;

  localparam logic [15:0] CMD_WHOAMI    = 16'h8F00;
  localparam logic [7:0]  OUT_X_L_RD_AI = 8'hE8;
  localparam logic [5:0]  NBITS_16      = 6'd15;
  localparam logic [5:0]  NBITS_24      = 6'd23;

  localparam int INIT_LEN = 3;
  // Entry 0 is sent first: CTRL_REG1, TEMP_CFG, CTRL_REG4 (BDU + HR).
  localparam logic [INIT_LEN-1:0][15:0] INIT_TABLE = {16'h2388, 16'h1FC0, 16'h2077};

  localparam logic [7:0] LED_NEG = 8'hE0;
  localparam logic [7:0] LED_POS = 8'h07;
  localparam logic [7:0] LED_CEN = 8'h18;

  function automatic cls_t classify(input logic [7:0] hi, input logic signed [7:0] th);
    logic signed [7:0] h;
    h = $signed(hi);
    if (h < -th) return CLS_NEG;
    if (h > th)  return CLS_POS;
    return CLS_CEN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_axis_cmp.sv
`default_nettype none
// accel_axis_cmp: signed 8-bit threshold band on one axis high byte; direction
// holds while the sample sits inside the band. Rev 1.0
module accel_axis_cmp
  import accel_seq_pkg::*;
#(
  parameter int THRESH = 32
) (
  input  logic       clk_in,
  input  logic       nrst,
  input  logic       en,
  input  logic [7:0] hi_byte,
  output logic       direction,
  output logic       centred
);

  localparam logic signed [7:0] TH = 8'(THRESH);

  cls_t cls;
  assign cls = classify(hi_byte, TH);

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      direction <= 1'b0;
      centred   <= 1'b0;
    end else if (en) begin
      case (cls)
        CLS_NEG: begin
          direction <= 1'b0;
          centred   <= 1'b0;
        end
        CLS_POS: begin
          direction <= 1'b1;
          centred   <= 1'b0;
        end
        default: centred <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_multi_axis_sequencer.sv
`default_nettype none
// accel_multi_axis_sequencer: LIS3DH probe/init, then periodic multi-axis reads
// over the 32-bit SPI master handshake with per-axis direction tracking. Rev 1.0
module accel_multi_axis_sequencer
  import accel_seq_pkg::*;
#(
  parameter int         NUM_AXES    = 3,
  parameter int         SAMPLE_DIV  = 50000,
  parameter int         THRESH      = 32,
  parameter logic [7:0] WHOAMI_ID   = 8'h33,
  parameter int         MAX_RETRY   = 3,
  parameter int         SPI_TIMEOUT = 4096
) (
  input  logic                     clk_in,
  input  logic                     nrst,
  output logic [31:0]              spi_mosi_data,
  input  logic [31:0]              spi_miso_data,
  output logic [5:0]               spi_nbits,
  output logic                     spi_request,
  input  logic                     spi_ready,
  output logic [16*NUM_AXES-1:0]   acc_data,
  output logic                     acc_valid,
  output logic [NUM_AXES-1:0]      direction,
  output logic [NUM_AXES-1:0]      centred,
  output logic                     fault,
  output logic [7:0]               led_out
);

  localparam int PW = $clog2(SAMPLE_DIV + 1);
  localparam int WW = $clog2(SPI_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0]    PERIOD_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0]    PERIOD_ONE  = (SAMPLE_DIV > 1) ? PW'(1) : '0;
  localparam logic [WW-1:0]    WAIT_LAST   = WW'(SPI_TIMEOUT - 1);
  localparam logic [RW-1:0]    RETRY_LAST  = RW'(MAX_RETRY - 1);
  localparam logic [1:0]       AXIS_LAST   = 2'(NUM_AXES - 1);
  localparam logic [1:0]       INIT_LAST   = 2'(INIT_LEN - 1);
  localparam logic signed [7:0] TH         = 8'(THRESH);

  generate
    if (NUM_AXES < 1 || NUM_AXES > 3) begin : g_bad_axes
      $error("NUM_AXES must be in 1..3");
    end
    if (THRESH < 1 || THRESH > 127) begin : g_bad_thresh
      $error("THRESH must be in 1..127");
    end
    if (SAMPLE_DIV < 1 || MAX_RETRY < 1 || SPI_TIMEOUT < 1) begin : g_bad_counts
      $error("SAMPLE_DIV, MAX_RETRY and SPI_TIMEOUT must be >= 1");
    end
  endgenerate

  state_t          state, next_state;
  logic            issue_en;
  logic [RW-1:0]   retry;
  logic [1:0]      axis;
  logic [1:0]      init_idx;
  logic [WW-1:0]   wait_cnt;
  logic [PW-1:0]   period_cnt;
  logic            wait_expired;
  logic [7:0]      read_cmd;
  logic            unused_miso;

  assign wait_expired = !spi_ready && (wait_cnt == WAIT_LAST);
  assign read_cmd     = OUT_X_L_RD_AI + {5'd0, axis, 1'b0};
  assign unused_miso  = ^spi_miso_data[31:16];

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) state <= WHOAMI;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WHOAMI:      if (issue_en) next_state = WHOAMI_WAIT;
      WHOAMI_WAIT: if (spi_ready) next_state = CHECK;
                   else if (wait_expired) next_state = FAULT;
      CHECK:       if (led_out == WHOAMI_ID) next_state = INIT;
                   else if (retry == RETRY_LAST) next_state = FAULT;
                   else next_state = WHOAMI;
      INIT:        next_state = INIT_WAIT;
      INIT_WAIT:   if (spi_ready) next_state = (init_idx == INIT_LAST) ? READ : INIT;
                   else if (wait_expired) next_state = FAULT;
      READ:        next_state = READ_WAIT;
      READ_WAIT:   if (spi_ready) next_state = (axis == AXIS_LAST) ? COMPARE : READ;
                   else if (wait_expired) next_state = FAULT;
      COMPARE:     next_state = PERIOD;
      PERIOD:      if (period_cnt == PERIOD_LAST) next_state = READ;
      FAULT:       next_state = FAULT;
      default:     next_state = WHOAMI;
    endcase
  end

  // issue_en keeps the first post-reset cycle quiet so every output reads 0 in reset.
  always_comb begin
    spi_request   = 1'b0;
    spi_nbits     = '0;
    spi_mosi_data = '0;
    if (issue_en) begin
      case (state)
        WHOAMI: begin
          spi_request   = 1'b1;
          spi_nbits     = NBITS_16;
          spi_mosi_data = {16'h0000, CMD_WHOAMI};
        end
        INIT: begin
          spi_request   = 1'b1;
          spi_nbits     = NBITS_16;
          spi_mosi_data = {16'h0000, INIT_TABLE[init_idx]};
        end
        READ: begin
          spi_request   = 1'b1;
          spi_nbits     = NBITS_24;
          spi_mosi_data = {8'h00, read_cmd, 16'h0000};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      issue_en   <= 1'b0;
      retry      <= '0;
      axis       <= '0;
      init_idx   <= '0;
      wait_cnt   <= '0;
      period_cnt <= '0;
      acc_data   <= '0;
      acc_valid  <= 1'b0;
      fault      <= 1'b0;
      led_out    <= '0;
    end else begin
      issue_en  <= 1'b1;
      acc_valid <= (state == COMPARE);
      fault     <= (next_state == FAULT);

      if (state != next_state)       wait_cnt <= '0;
      else if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + WW'(1);

      // Round start is the axis-0 READ issue; the count saturates at the period end.
      if (state == READ && axis == 2'd0) period_cnt <= PERIOD_ONE;
      else if (period_cnt != PERIOD_LAST) period_cnt <= period_cnt + PW'(1);

      case (state)
        WHOAMI_WAIT: if (spi_ready) led_out <= spi_miso_data[7:0];
        CHECK: begin
          if (led_out == WHOAMI_ID) init_idx <= '0;
          else                      retry    <= retry + RW'(1);
        end
        INIT_WAIT: if (spi_ready) begin
          init_idx <= init_idx + 2'd1;
          axis     <= '0;
        end
        READ_WAIT: if (spi_ready) begin
          for (int i = 0; i < NUM_AXES; i++) begin
            if (axis == 2'(i)) acc_data[16*i +: 16] <= {spi_miso_data[7:0], spi_miso_data[15:8]};
          end
          axis <= (axis == AXIS_LAST) ? 2'd0 : axis + 2'd1;
        end
        COMPARE: begin
          case (classify(acc_data[15:8], TH))
            CLS_NEG: led_out <= LED_NEG;
            CLS_POS: led_out <= LED_POS;
            default: led_out <= LED_CEN;
          endcase
        end
        default: ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_AXES; g++) begin : g_axis
      accel_axis_cmp #(
        .THRESH (THRESH)
      ) u_cmp (
        .clk_in    (clk_in),
        .nrst      (nrst),
        .en        (state == COMPARE),
        .hi_byte   (acc_data[16*g+15 -: 8]),
        .direction (direction[g]),
        .centred   (centred[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_accel_multi_axis_sequencer.sv
`default_nettype none
// tb_accel_multi_axis_sequencer: scoreboard bench with an LIS3DH-style SPI responder
// and a behavioural model of the threshold-band direction tracking.
module tb_accel_multi_axis_sequencer;

  localparam int NAX = 3;
  localparam int SDIV = 200;
  localparam int TH = 32;
  localparam int TMO = 64;
  localparam int RETRIES = 3;

  logic        clk_in = 1'b0;
  logic        nrst;
  logic [31:0] spi_mosi_data;
  logic [31:0] spi_miso_data;
  logic [5:0]  spi_nbits;
  logic        spi_request;
  logic        spi_ready;
  logic [47:0] acc_data;
  logic        acc_valid;
  logic [2:0]  direction;
  logic [2:0]  centred;
  logic        fault;
  logic [7:0]  led_out;

  typedef struct packed { logic [5:0] nbits; logic [31:0] mosi; } frame_t;
  typedef struct packed { logic [2:0][7:0] hi; logic [2:0][7:0] lo; } round_in_t;
  typedef struct packed { logic [47:0] data; logic [2:0] dir; logic [2:0] cen; logic [7:0] led; } round_exp_t;

  frame_t     exp_frames[$];
  round_exp_t exp_rounds[$];
  round_in_t  rounds_q[$];

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         frames_seen = 0;
  int         valid_seen = 0;
  int         last_valid = -1;
  logic [7:0] who_val = 8'h33;
  bit         withhold_when_empty = 1'b0;
  bit [2:0]   m_dir = '0;
  logic [47:0] last_data = '0;

  accel_multi_axis_sequencer #(
    .NUM_AXES    (NAX),
    .SAMPLE_DIV  (SDIV),
    .THRESH      (TH),
    .WHOAMI_ID   (8'h33),
    .MAX_RETRY   (RETRIES),
    .SPI_TIMEOUT (TMO)
  ) dut (
    .clk_in        (clk_in),
    .nrst          (nrst),
    .spi_mosi_data (spi_mosi_data),
    .spi_miso_data (spi_miso_data),
    .spi_nbits     (spi_nbits),
    .spi_request   (spi_request),
    .spi_ready     (spi_ready),
    .acc_data      (acc_data),
    .acc_valid     (acc_valid),
    .direction     (direction),
    .centred       (centred),
    .fault         (fault),
    .led_out       (led_out)
  );

  initial forever #5 clk_in = ~clk_in;
  initial forever begin @(posedge clk_in); cyc++; end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: high byte outside the band sets direction by sign, inside holds it.
  function automatic round_exp_t model_round(input round_in_t r);
    round_exp_t e;
    int h;
    e = '0;
    for (int a = 0; a < NAX; a++) begin
      h = int'($signed(r.hi[a]));
      e.data[16*a +: 16] = {r.hi[a], r.lo[a]};
      if (h < -TH) begin m_dir[a] = 1'b0; e.cen[a] = 1'b0; end
      else if (h > TH) begin m_dir[a] = 1'b1; e.cen[a] = 1'b0; end
      else e.cen[a] = 1'b1;
      if (a == 0) e.led = (h < -TH) ? 8'hE0 : ((h > TH) ? 8'h07 : 8'h18);
    end
    e.dir = m_dir;
    return e;
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 5))
      0:       return 8'(TH);
      1:       return 8'(-TH);
      2:       return 8'(TH + 1);
      3:       return 8'(-TH - 1);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic push_frame(input logic [5:0] nb, input logic [31:0] mosi);
    frame_t f;
    f.nbits = nb;
    f.mosi  = mosi;
    exp_frames.push_back(f);
  endtask

  task automatic push_startup();
    push_frame(6'd15, 32'h0000_8F00);
    push_frame(6'd15, 32'h0000_2077);
    push_frame(6'd15, 32'h0000_1FC0);
    push_frame(6'd15, 32'h0000_2388);
  endtask

  task automatic push_round(input bit directed, input logic [7:0] h0);
    round_in_t  r;
    round_exp_t e;
    for (int a = 0; a < NAX; a++) begin
      r.hi[a] = rnd_byte();
      r.lo[a] = 8'($urandom);
      push_frame(6'd23, {8'h00, 8'(8'hE8 + 2*a), 16'h0000});
    end
    if (directed) r.hi[0] = h0;
    rounds_q.push_back(r);
    e = model_round(r);
    exp_rounds.push_back(e);
    last_data = e.data;
  endtask

  task automatic clear_model();
    exp_frames.delete();
    exp_rounds.delete();
    rounds_q.delete();
    m_dir = '0;
    last_valid = -1;
    frames_seen = 0;
    valid_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    nrst = 1'b0;
    clear_model();
    repeat (3) @(negedge clk_in);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    nrst = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_frames.size() != 0 || exp_rounds.size() != 0) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    n_checks++;
    if (n < budget) n_pass++;
    else $display("FAIL %s: timed out with %0d frames and %0d rounds outstanding, expected 0",
                  name, exp_frames.size(), exp_rounds.size());
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_acc_data"},  64'(acc_data), 64'(0));
    check({tag, "_acc_valid"}, 64'(acc_valid), 64'(0));
    check({tag, "_direction"}, 64'(direction), 64'(0));
    check({tag, "_centred"},   64'(centred), 64'(0));
    check({tag, "_fault"},     64'(fault), 64'(0));
    check({tag, "_led_out"},   64'(led_out), 64'(0));
    check({tag, "_request"},   64'(spi_request), 64'(0));
    check({tag, "_nbits"},     64'(spi_nbits), 64'(0));
    check({tag, "_mosi"},      64'(spi_mosi_data), 64'(0));
  endtask

  // SPI responder: answers one cycle after each request unless a read is withheld.
  initial begin : spi_slave
    bit          busy;
    int          cnt;
    int          ax;
    logic [31:0] pend;
    round_in_t   cur;
    busy = 1'b0;
    cnt = 0;
    pend = '0;
    cur = '0;
    spi_ready = 1'b0;
    spi_miso_data = '0;
    forever begin
      @(negedge clk_in);
      spi_ready = 1'b0;
      if (!nrst) busy = 1'b0;
      else if (busy) begin
        if (cnt <= 1) begin
          spi_ready = 1'b1;
          spi_miso_data = pend;
          busy = 1'b0;
        end else cnt--;
      end else if (spi_request) begin
        busy = 1'b1;
        cnt = 1;
        pend = $urandom;
        if (spi_nbits == 6'd15 && spi_mosi_data[15:0] == 16'h8F00) begin
          pend = {24'h0, who_val};
        end else if (spi_nbits == 6'd23) begin
          ax = int'(spi_mosi_data[23:16] - 8'hE8) / 2;
          if (ax == 0) begin
            if (rounds_q.size() == 0) begin
              cur = '0;
              if (withhold_when_empty) busy = 1'b0;
            end else cur = rounds_q.pop_front();
          end
          if (ax >= 0 && ax < NAX) pend = {16'($urandom), cur.lo[ax], cur.hi[ax]};
        end
      end
    end
  end

  initial begin : monitor
    frame_t     f;
    round_exp_t e;
    forever begin
      @(negedge clk_in);
      if (nrst) begin
        if (spi_request) begin
          frames_seen++;
          if (exp_frames.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got nbits=%0d mosi=%h, expected no request", spi_nbits, spi_mosi_data);
          end else begin
            f = exp_frames.pop_front();
            check("frame_nbits", 64'(spi_nbits), 64'(f.nbits));
            check("frame_mosi", 64'(spi_mosi_data), 64'(f.mosi));
          end
        end
        if (acc_valid) begin
          valid_seen++;
          if (last_valid >= 0) check("valid_spacing", 64'(cyc - last_valid), 64'(SDIV));
          last_valid = cyc;
          if (exp_rounds.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got acc_data=%h, expected no round", acc_data);
          end else begin
            e = exp_rounds.pop_front();
            check("round_data", 64'(acc_data), 64'(e.data));
            check("round_direction", 64'(direction), 64'(e.dir));
            check("round_centred", 64'(centred), 64'(e.cen));
            check("round_led", 64'(led_out), 64'(e.led));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    logic [7:0] directed_h0 [8];
    directed_h0 = '{8'h40, 8'h10, 8'hC0, 8'h20, 8'hE0, 8'h40, 8'hE0, 8'h20};
    nrst = 1'b0;

    // Healthy device: probe, init, then directed and random rounds.
    do_reset();
    check_outputs_zero("reset");
    who_val = 8'h33;
    withhold_when_empty = 1'b0;
    push_startup();
    foreach (directed_h0[i]) push_round(1'b1, directed_h0[i]);
    repeat (5) push_round(1'b0, 8'h00);
    release_reset();
    wait_idle("normal_run", 6000);
    check("normal_fault", 64'(fault), 64'(0));

    // Wrong ID every time: exactly MAX_RETRY probes then fault and silence.
    do_reset();
    who_val = 8'h00;
    repeat (RETRIES) push_frame(6'd15, 32'h0000_8F00);
    release_reset();
    wait_idle("id_probes", 500);
    repeat (1000) @(negedge clk_in);
    check("id_fault", 64'(fault), 64'(1));
    check("id_frames", 64'(frames_seen), 64'(RETRIES));
    check("id_led", 64'(led_out), 64'(8'h00));
    check("id_valid", 64'(valid_seen), 64'(0));

    // Read response withheld: fault after exactly SPI_TIMEOUT wait cycles.
    do_reset();
    who_val = 8'h33;
    withhold_when_empty = 1'b1;
    push_startup();
    push_round(1'b1, 8'h40);
    push_frame(6'd23, 32'h00E8_0000);
    release_reset();
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(spi_request && spi_nbits == 6'd23 && exp_rounds.size() == 0) && n < 3000);
    check("timeout_reached_read", 64'(n < 3000), 64'(1));
    repeat (TMO) @(negedge clk_in);
    check("timeout_not_early", 64'(fault), 64'(0));
    @(negedge clk_in);
    check("timeout_fault", 64'(fault), 64'(1));
    repeat (300) @(negedge clk_in);
    check("timeout_frames", 64'(frames_seen), 64'(8));
    check("timeout_valid", 64'(valid_seen), 64'(1));
    check("timeout_data_hold", 64'(acc_data), 64'(last_data));

    // Reset pulsed while a read waits: outputs clear at once and probing restarts.
    do_reset();
    withhold_when_empty = 1'b1;
    push_startup();
    push_round(1'b1, 8'hC0);
    push_round(1'b0, 8'h00);
    push_frame(6'd23, 32'h00E8_0000);
    release_reset();
    wait_idle("midreset_setup", 3000);
    repeat (5) @(negedge clk_in);
    nrst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    clear_model();
    withhold_when_empty = 1'b0;
    push_startup();
    push_round(1'b1, 8'h10);
    repeat (2) @(negedge clk_in);
    release_reset();
    wait_idle("after_reset", 3000);
    check("after_reset_fault", 64'(fault), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
